// File: rtl/cpu10_pkg.sv
// rtl/cpu10_pkg.sv - shared widths, ALU opcodes and pipeline register layouts for the 10-bit CPU
package cpu10_pkg;

  localparam int W  = 10;
  localparam int RA = 3;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_NAND = 3'b011;
  localparam logic [2:0] ALU_SLR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_HALT = 3'b110;

  typedef struct packed {
    logic [RA-1:0] src_a;
    logic [RA-1:0] src_b;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [2:0]    alu_ctrl;
    logic          reg_we;
    logic          mem_we;
    logic          mem_re;
    logic [W-1:0]  store_data;
  } fd_em_t;

  typedef struct packed {
    logic [W-1:0]  alu_result;
    logic [W-1:0]  mem_rdata;
    logic          reg_we;
    logic          mem_re;
    logic [RA-1:0] dest;
  } em_wb_t;

endpackage

// File: rtl/cpu10_exec_wb_pipe_if.sv
// rtl/cpu10_exec_wb_pipe_if.sv - decode-side inputs, data RAM port and writeback outputs of the EM/WB pipe
interface cpu10_exec_wb_pipe_if;
  import cpu10_pkg::*;

  logic [RA-1:0] fd_srcA_addr;
  logic [RA-1:0] fd_srcB_addr;
  logic [W-1:0]  fd_opA;
  logic [W-1:0]  fd_opB;
  logic [2:0]    fd_alu_ctrl;
  logic          fd_reg_we;
  logic          fd_mem_we;
  logic          fd_mem_re;
  logic [W-1:0]  fd_store_data;
  logic [W-1:0]  mem_addr;
  logic          mem_we;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          em_halt;
  logic          wb_reg_we;
  logic [RA-1:0] wb_dest;
  logic [W-1:0]  wb_wdata;
  logic          wb_mem_re;

  modport master (
    output fd_srcA_addr, fd_srcB_addr, fd_opA, fd_opB, fd_alu_ctrl,
           fd_reg_we, fd_mem_we, fd_mem_re, fd_store_data, mem_rdata,
    input  mem_addr, mem_we, mem_wdata, em_halt, wb_reg_we, wb_dest,
           wb_wdata, wb_mem_re
  );

  modport slave (
    input  fd_srcA_addr, fd_srcB_addr, fd_opA, fd_opB, fd_alu_ctrl,
           fd_reg_we, fd_mem_we, fd_mem_re, fd_store_data, mem_rdata,
    output mem_addr, mem_we, mem_wdata, em_halt, wb_reg_we, wb_dest,
           wb_wdata, wb_mem_re
  );

endinterface

// File: rtl/cpu10_alu.sv
// rtl/cpu10_alu.sv - combinational 10-bit ALU with wrap-around arithmetic and halt decode
module cpu10_alu
  import cpu10_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   alu_ctrl,
  output logic [W-1:0] result,
  output logic         halt
);

  logic [3:0] shamt;
  assign shamt = b[3:0];

  always_comb begin
    result = '0;
    halt   = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NAND: result = ~(a & b);
      // Shift amounts of 10..15 empty the word entirely
      ALU_SLR:  result = (shamt >= 4'd10) ? '0 : (a >> shamt);
      ALU_SLL:  result = (shamt >= 4'd10) ? '0 : (a << shamt);
      ALU_HALT: halt = 1'b1;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/cpu10_exec_wb_pipe.sv
// rtl/cpu10_exec_wb_pipe.sv - FD->EM register, EM stage with WB forwarding and RAM drive, EM->WB register
module cpu10_exec_wb_pipe
  import cpu10_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cpu10_exec_wb_pipe_if.slave  bus
);

  fd_em_t       em_q, em_d;
  em_wb_t       wb_q, wb_d;
  logic [W-1:0] wb_wdata;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         fwd_a, fwd_b, alu_halt;

  always_comb begin
    em_d            = '0;
    em_d.src_a      = bus.fd_srcA_addr;
    em_d.src_b      = bus.fd_srcB_addr;
    em_d.op_a       = bus.fd_opA;
    em_d.op_b       = bus.fd_opB;
    em_d.alu_ctrl   = bus.fd_alu_ctrl;
    em_d.reg_we     = bus.fd_reg_we;
    em_d.mem_we     = bus.fd_mem_we;
    em_d.mem_re     = bus.fd_mem_re;
    em_d.store_data = bus.fd_store_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_q <= '0;
      wb_q <= '0;
    end else begin
      em_q <= em_d;
      wb_q <= wb_d;
    end
  end

  // A LOAD in WB forwards its RAM data, so dependent instructions need no stall
  assign wb_wdata = wb_q.mem_re ? wb_q.mem_rdata : wb_q.alu_result;

  always_comb begin
    fwd_a = wb_q.reg_we && (wb_q.dest == em_q.src_a);
    fwd_b = wb_q.reg_we && (wb_q.dest == em_q.src_b);
    alu_a = fwd_a ? wb_wdata : em_q.op_a;
    alu_b = fwd_b ? wb_wdata : em_q.op_b;
  end

  cpu10_alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .alu_ctrl (em_q.alu_ctrl),
    .result   (alu_result),
    .halt     (alu_halt)
  );

  always_comb begin
    wb_d            = '0;
    wb_d.alu_result = alu_result;
    wb_d.mem_rdata  = bus.mem_rdata;
    wb_d.reg_we     = em_q.reg_we;
    wb_d.mem_re     = em_q.mem_re;
    wb_d.dest       = em_q.src_b;
  end

  assign bus.mem_addr  = alu_result;
  assign bus.mem_we    = em_q.mem_we;
  assign bus.mem_wdata = em_q.mem_we ? em_q.store_data : '0;
  assign bus.em_halt   = alu_halt;
  assign bus.wb_reg_we = wb_q.reg_we;
  assign bus.wb_dest   = wb_q.dest;
  assign bus.wb_wdata  = wb_wdata;
  assign bus.wb_mem_re = wb_q.mem_re;

endmodule

// File: tb/tb_cpu10_exec_wb_pipe.sv
// tb/tb_cpu10_exec_wb_pipe.sv - directed and randomized checks of the EM/WB pipe against a reference model
module tb_cpu10_exec_wb_pipe;

  logic clk;
  logic rst;
  bit   check_en;
  int   checks;
  int   failures;

  cpu10_exec_wb_pipe_if bus ();

  cpu10_exec_wb_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int srcA;
    int srcB;
    int opA;
    int opB;
    int ctrl;
    bit rwe;
    bit mwe;
    bit mre;
    int sd;
  } inst_t;

  inst_t m_em;
  int    m_wb_res, m_wb_rdata, m_wb_dest;
  bit    m_wb_we, m_wb_mre;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int to_signed10(int v);
    return (v >= 512) ? v - 1024 : v;
  endfunction

  function automatic int alu_ref(int a, int b, int c, output bit h);
    int sh;
    int r;
    sh = b % 16;
    h  = 1'b0;
    r  = 0;
    case (c)
      0: r = (a + b) % 1024;
      1: r = (a - b + 1024) % 1024;
      2: r = (to_signed10(a) < to_signed10(b)) ? 1 : 0;
      3: r = (~(a & b)) & 1023;
      4: r = (sh >= 10) ? 0 : (a >> sh);
      5: r = (sh >= 10) ? 0 : ((a << sh) % 1024);
      6: h = 1'b1;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int m_wbw();
    return m_wb_mre ? m_wb_rdata : m_wb_res;
  endfunction

  function automatic int em_res(output bit h);
    int a;
    int b;
    a = (m_wb_we && m_wb_dest == m_em.srcA) ? m_wbw() : m_em.opA;
    b = (m_wb_we && m_wb_dest == m_em.srcB) ? m_wbw() : m_em.opB;
    return alu_ref(a, b, m_em.ctrl, h);
  endfunction

  // Reference pipeline: each edge moves the EM instruction's outcome into WB and latches new inputs
  always @(posedge clk or posedge rst) begin : model
    bit h;
    if (rst) begin
      m_em      = '{default: 0};
      m_wb_res  = 0;
      m_wb_rdata = 0;
      m_wb_dest = 0;
      m_wb_we   = 1'b0;
      m_wb_mre  = 1'b0;
    end else begin
      m_wb_res   = em_res(h);
      m_wb_rdata = int'(bus.mem_rdata);
      m_wb_we    = m_em.rwe;
      m_wb_mre   = m_em.mre;
      m_wb_dest  = m_em.srcB;
      m_em.srcA  = int'(bus.fd_srcA_addr);
      m_em.srcB  = int'(bus.fd_srcB_addr);
      m_em.opA   = int'(bus.fd_opA);
      m_em.opB   = int'(bus.fd_opB);
      m_em.ctrl  = int'(bus.fd_alu_ctrl);
      m_em.rwe   = bus.fd_reg_we;
      m_em.mwe   = bus.fd_mem_we;
      m_em.mre   = bus.fd_mem_re;
      m_em.sd    = int'(bus.fd_store_data);
    end
  end

  always @(negedge clk) begin : compare
    bit h;
    int r;
    if (check_en && !rst) begin
      r = em_res(h);
      chk("mem_addr",  int'(bus.mem_addr),  r);
      chk("mem_we",    int'(bus.mem_we),    int'(m_em.mwe));
      chk("mem_wdata", int'(bus.mem_wdata), m_em.mwe ? m_em.sd : 0);
      chk("em_halt",   int'(bus.em_halt),   int'(h));
      chk("wb_reg_we", int'(bus.wb_reg_we), int'(m_wb_we));
      chk("wb_dest",   int'(bus.wb_dest),   m_wb_dest);
      chk("wb_wdata",  int'(bus.wb_wdata),  m_wbw());
      chk("wb_mem_re", int'(bus.wb_mem_re), int'(m_wb_mre));
    end
  end

  task automatic drive(int sa, int sb, int a, int b, int c, bit rwe, bit mwe, bit mre, int sd);
    bus.fd_srcA_addr  = 3'(sa);
    bus.fd_srcB_addr  = 3'(sb);
    bus.fd_opA        = 10'(a);
    bus.fd_opB        = 10'(b);
    bus.fd_alu_ctrl   = 3'(c);
    bus.fd_reg_we     = rwe;
    bus.fd_mem_we     = mwe;
    bus.fd_mem_re     = mre;
    bus.fd_store_data = 10'(sd);
  endtask

  task automatic send(int sa, int sb, int a, int b, int c, bit rwe, bit mwe, bit mre, int sd);
    drive(sa, sb, a, b, c, rwe, mwe, mre, sd);
    @(posedge clk);
    #2;
  endtask

  task automatic bubble();
    send(6, 6, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_mem_addr"},  int'(bus.mem_addr),  0);
    chk({tag, "_mem_we"},    int'(bus.mem_we),    0);
    chk({tag, "_mem_wdata"}, int'(bus.mem_wdata), 0);
    chk({tag, "_em_halt"},   int'(bus.em_halt),   0);
    chk({tag, "_wb_reg_we"}, int'(bus.wb_reg_we), 0);
    chk({tag, "_wb_dest"},   int'(bus.wb_dest),   0);
    chk({tag, "_wb_wdata"},  int'(bus.wb_wdata),  0);
    chk({tag, "_wb_mem_re"}, int'(bus.wb_mem_re), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    check_en = 1'b0;
    rst      = 1'b1;
    bus.mem_rdata = '0;
    drive(5, 7, 10'h3FF, 10'h155, 6, 1'b1, 1'b1, 1'b1, 10'h2AA);
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    rst = 1'b0;
    check_en = 1'b1;

    // ALU sweep, no register writes in flight
    send(4, 5, 5, 3, 0, 1'b0, 1'b0, 1'b0, 0);  chk("add_5_3", int'(bus.mem_addr), 8);
    send(4, 5, 5, 3, 1, 1'b0, 1'b0, 1'b0, 0);  chk("sub_5_3", int'(bus.mem_addr), 2);
    send(4, 5, 5, 3, 2, 1'b0, 1'b0, 1'b0, 0);  chk("slt_5_3", int'(bus.mem_addr), 0);
    send(4, 5, 5, 3, 3, 1'b0, 1'b0, 1'b0, 0);  chk("nand_5_3", int'(bus.mem_addr), 10'h3FE);
    send(4, 5, 10'h3FF, 1, 0, 1'b0, 1'b0, 1'b0, 0); chk("add_wrap", int'(bus.mem_addr), 0);
    send(4, 5, 10'h3FF, 1, 2, 1'b0, 1'b0, 1'b0, 0); chk("slt_m1_1", int'(bus.mem_addr), 1);
    send(4, 5, 1, 9, 5, 1'b0, 1'b0, 1'b0, 0);  chk("sll_1_9", int'(bus.mem_addr), 10'h200);
    send(4, 5, 10'h200, 12, 4, 1'b0, 1'b0, 1'b0, 0); chk("slr_big", int'(bus.mem_addr), 0);
    send(4, 5, 10'h200, 9, 4, 1'b0, 1'b0, 1'b0, 0);  chk("slr_9", int'(bus.mem_addr), 1);

    // Latency: result appears in WB exactly two edges after injection
    send(0, 1, 2, 3, 0, 1'b1, 1'b0, 1'b0, 0);
    chk("lat_em_wbwe", int'(bus.wb_reg_we), 0);
    bubble();
    chk("lat_wb_wdata", int'(bus.wb_wdata), 5);
    chk("lat_wb_we",    int'(bus.wb_reg_we), 1);
    chk("lat_wb_dest",  int'(bus.wb_dest), 1);

    // Forwarding onto A, B, both, and suppressed when the WB instruction does not write
    send(0, 1, 3, 4, 0, 1'b1, 1'b0, 1'b0, 0);
    send(1, 6, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);  chk("fwd_a", int'(bus.mem_addr), 7);
    send(0, 1, 3, 4, 0, 1'b1, 1'b0, 1'b0, 0);
    send(6, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);  chk("fwd_b", int'(bus.mem_addr), 7);
    send(0, 1, 3, 4, 0, 1'b1, 1'b0, 1'b0, 0);
    send(1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);  chk("fwd_ab", int'(bus.mem_addr), 14);
    send(0, 1, 3, 4, 0, 1'b0, 1'b0, 1'b0, 0);
    send(1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);  chk("no_fwd", int'(bus.mem_addr), 0);

    // Memory: store, non-store, load followed by dependent instruction
    send(0, 6, 4, 0, 0, 1'b0, 1'b1, 1'b0, 10'h0AB);
    chk("st_we",    int'(bus.mem_we), 1);
    chk("st_addr",  int'(bus.mem_addr), 4);
    chk("st_wdata", int'(bus.mem_wdata), 10'h0AB);
    send(0, 6, 4, 0, 0, 1'b0, 1'b0, 1'b0, 10'h3C3);
    chk("nst_wdata", int'(bus.mem_wdata), 0);
    send(0, 2, 10'h10, 0, 0, 1'b1, 1'b0, 1'b1, 0);
    bus.mem_rdata = 10'h155;
    send(2, 6, 0, 1, 0, 1'b0, 1'b0, 1'b0, 0);
    bus.mem_rdata = '0;
    chk("ld_wdata", int'(bus.wb_wdata), 10'h155);
    chk("ld_mre",   int'(bus.wb_mem_re), 1);
    chk("ld_use",   int'(bus.mem_addr), 10'h156);

    // HALT lasts exactly one EM cycle; opcode 111 does not halt
    send(0, 6, 9, 9, 6, 1'b0, 1'b0, 1'b0, 0);
    chk("halt_on",  int'(bus.em_halt), 1);
    chk("halt_res", int'(bus.mem_addr), 0);
    send(0, 6, 9, 9, 7, 1'b0, 1'b0, 1'b0, 0);
    chk("halt_111", int'(bus.em_halt), 0);
    chk("res_111",  int'(bus.mem_addr), 0);

    // Randomized traffic over a small register window so forwarding fires often
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #2;
        chk_all_zero("midrst_hold");
        rst = 1'b0;
      end
      bus.mem_rdata = 10'($urandom_range(0, 1023));
      send($urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1023), $urandom_range(0, 1023),
           $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 1023));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
